// File: rtl/adpcm_pkg.sv
// Shared constants and types for the ADPCM scale-factor adaptation stage.
package adpcm_pkg;

  localparam int W_WI = 12;
  localparam int W_Y  = 13;
  localparam int W_YL = 19;
  localparam int W_AL = 7;

  localparam logic [W_Y-1:0]  YU_MIN   = 13'd544;
  localparam logic [W_Y-1:0]  YU_MAX   = 13'd5120;
  localparam logic [W_YL-1:0] YL_RESET = 19'd34816;

  typedef enum logic [3:0] {
    S_IDLE,
    S_UPD,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_MUL4,
    S_MUL5,
    S_MUL6,
    S_DONE
  } sfa_state_t;

endpackage

// File: rtl/sfa_serial_mul.sv
// 13x7 unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// start is asserted for the first bit cycle; done is asserted combinationally in the
// seventh cycle together with the final product (already shifted right by 6).
// Operands must be held stable from start through done.
module sfa_serial_mul
  import adpcm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [W_Y-1:0]    a_i,
  input  logic [W_AL-1:0]   b_i,
  output logic              done_o,
  output logic [13:0]       prod_o
);

  logic [19:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [2:0]  idx;
  logic        step;

  // Accumulate a<<idx for the current multiplier bit; start restarts from zero.
  always_comb begin
    step   = start_i | busy_q;
    idx    = start_i ? 3'd0 : cnt_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_o = 1'b0;
    if (step) begin
      acc_d  = (start_i ? 20'd0 : acc_q) + (b_i[idx] ? ({7'b0, a_i} << idx) : 20'd0);
      cnt_d  = idx + 3'd1;
      busy_d = (idx != 3'd6);
      done_o = (idx == 3'd6);
    end
    prod_o = acc_d[19:6];
  end

  // Accumulator, bit counter and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/scale_factor_adapt.sv
// Quantizer scale-factor adaptation: FILTD/LIMB/FILTE update of YU/YL, then the
// AL-weighted mix into the next-sample Y using a serial multiplier.
// Optional macro LIMIT_STATUS_EN adds the sticky lim_flags output.
module scale_factor_adapt
  import adpcm_pkg::*;
#(
  parameter logic [W_Y-1:0]  YU_RST = 13'd544,
  parameter logic [W_YL-1:0] YL_RST = YL_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wi_valid,
  input  logic [W_WI-1:0]   wi,
  input  logic [W_AL-1:0]   al,
  output logic              wi_ready,
  output logic [W_Y-1:0]    y,
  output logic [W_YL-1:0]   yl,
  output logic              y_valid
`ifdef LIMIT_STATUS_EN
  ,
  output logic [1:0]        lim_flags
`endif
);

  sfa_state_t state_q, state_d;

  logic [W_WI-1:0] wi_q;
  logic [W_AL-1:0] al_q;
  logic [W_Y-1:0]  yu_q;
  logic [W_YL-1:0] ylf_q;   // working YL
  logic [W_Y-1:0]  y_q;
  logic [W_YL-1:0] yl_q;    // published YL

  logic accept;
  assign accept = wi_valid && (state_q == S_IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Fixed-length sequence: one update cycle, seven multiply cycles, one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wi_valid) state_d = S_UPD;
      S_UPD:   state_d = S_MUL0;
      S_MUL0:  state_d = S_MUL1;
      S_MUL1:  state_d = S_MUL2;
      S_MUL2:  state_d = S_MUL3;
      S_MUL3:  state_d = S_MUL4;
      S_MUL4:  state_d = S_MUL5;
      S_MUL5:  state_d = S_MUL6;
      S_MUL6:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture WI/AL on accept; held for the whole computation.
  always_ff @(posedge clk) begin
    if (reset) begin
      wi_q <= '0;
      al_q <= '0;
    end else if (accept) begin
      wi_q <= wi;
      al_q <= al;
    end
  end

  // FILTD: ((WI<<5) - y) >> 5 taken directly as WI - ceil(y/32), 12 bits.
  logic [11:0] difsx_lo;
  logic [12:0] difsx, yut, yup;
  logic        clamp_lo, clamp_hi;
  // FILTE: (YUP - YL) >> 6 taken as hi-part difference minus low-part borrow, 14 bits.
  logic [13:0] d_hi;
  logic [18:0] dx, ylp;

  // Update datapath, evaluated from the old y and working YL.
  always_comb begin
    difsx_lo = wi_q - {4'b0, y_q[12:5]} - {11'b0, |y_q[4:0]};
    difsx    = {difsx_lo[11], difsx_lo};
    yut      = y_q + difsx;
    clamp_lo = (yut < YU_MIN);
    clamp_hi = (yut > YU_MAX);
    yup      = clamp_lo ? YU_MIN : (clamp_hi ? YU_MAX : yut);
    d_hi     = {7'b0, yup[12:6]} - {1'b0, ylf_q[18:6]}
               - {13'b0, (ylf_q[5:0] > yup[5:0])};
    dx       = {{5{d_hi[13]}}, d_hi};
    ylp      = ylf_q + dx;
  end

  // MIX: signed difference YU - YL>>6 as sign/magnitude for the unsigned multiplier.
  logic [12:0] yl_sh, difm, y_nxt;
  logic [13:0] dif14, dif_neg, prodm, prod;
  logic        difs, mul_done;

  always_comb begin
    yl_sh   = ylf_q[18:6];
    dif14   = {1'b0, yu_q} - {1'b0, yl_sh};
    difs    = dif14[13];
    dif_neg = 14'd0 - dif14;
    difm    = difs ? dif_neg[12:0] : dif14[12:0];
    prod    = difs ? (14'd0 - prodm) : prodm;
    y_nxt   = yl_sh + prod[12:0];
  end

  sfa_serial_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (state_q == S_MUL0),
    .a_i     (difm),
    .b_i     (al_q),
    .done_o  (mul_done),
    .prod_o  (prodm)
  );

  // Scale-factor state: YU/YL on the update edge, y/yl when the product is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      yu_q  <= YU_RST;
      ylf_q <= YL_RST;
      y_q   <= YU_RST;
      yl_q  <= YL_RST;
    end else begin
      if (state_q == S_UPD) begin
        yu_q  <= yup;
        ylf_q <= ylp;
      end
      if (mul_done) begin
        y_q  <= y_nxt;
        yl_q <= ylf_q;
      end
    end
  end

`ifdef LIMIT_STATUS_EN
  logic [1:0] flags_q;

  // Sticky clamp flags, cleared when the next sample is accepted.
  always_ff @(posedge clk) begin
    if (reset)                  flags_q <= 2'b00;
    else if (accept)            flags_q <= 2'b00;
    else if (state_q == S_UPD)  flags_q <= flags_q | {clamp_hi, clamp_lo};
  end

  assign lim_flags = flags_q;
`endif

  assign wi_ready = (state_q == S_IDLE);
  assign y_valid  = (state_q == S_DONE);
  assign y        = y_q;
  assign yl       = yl_q;

endmodule
